// File: rtl/axi4_lite_ram_slave_if.sv
// rtl/axi4_lite_ram_slave_if.sv - AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views
interface axi4_lite_ram_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
   logic                  S_AXI_AWVALID;
   logic                  S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0] S_AXI_WDATA;
   logic [3:0]            S_AXI_WSTRB;
   logic                  S_AXI_WVALID;
   logic                  S_AXI_WREADY;
   logic [1:0]            S_AXI_BRESP;
   logic                  S_AXI_BVALID;
   logic                  S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
   logic                  S_AXI_ARVALID;
   logic                  S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0] S_AXI_RDATA;
   logic [1:0]            S_AXI_RRESP;
   logic                  S_AXI_RVALID;
   logic                  S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axi4_lite_ram_slave.sv
// rtl/axi4_lite_ram_slave.sv - word-addressed RAM behind an AXI4-Lite slave; optional AXI_RAM_RANGE_CHECK_EN
module axi4_lite_ram_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   axi4_lite_ram_slave_if.slave  s_axi
);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   w_state_t              w_state_q, w_state_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic                  aw_oor_q, aw_oor_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [3:0]            w_strb_q, w_strb_d;
   logic [1:0]            bresp_q, bresp_d;

   r_state_t              r_state_q, r_state_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;

   logic                  commit_en;
   logic [IDX_W-1:0]      commit_idx;
   logic                  commit_oor;
   logic [DATA_WIDTH-1:0] commit_data;
   logic [3:0]            commit_strb;

   logic                  aw_ready, w_ready, ar_ready;
   logic                  aw_hs, w_hs, ar_hs;
   logic [IDX_W-1:0]      aw_idx_in, ar_idx_in;
   logic                  aw_oor_in, ar_oor_in;

   assign aw_idx_in = s_axi.S_AXI_AWADDR[IDX_W+1:2];
   assign ar_idx_in = s_axi.S_AXI_ARADDR[IDX_W+1:2];

`ifdef AXI_RAM_RANGE_CHECK_EN
   assign aw_oor_in = |s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:IDX_W+2];
   assign ar_oor_in = |s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:IDX_W+2];
`else
   assign aw_oor_in = 1'b0;
   assign ar_oor_in = 1'b0;
`endif

   // Byte offset bits never select anything; upper bits only matter with the range check.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                               s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:IDX_W+2],
                               s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:IDX_W+2]};

   // Readies and valids are forced low while reset is asserted.
   assign aw_ready = !rst && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
   assign w_ready  = !rst && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
   assign ar_ready = !rst && (r_state_q == R_IDLE);

   assign aw_hs = s_axi.S_AXI_AWVALID && aw_ready;
   assign w_hs  = s_axi.S_AXI_WVALID  && w_ready;
   assign ar_hs = s_axi.S_AXI_ARVALID && ar_ready;

   assign s_axi.S_AXI_AWREADY = aw_ready;
   assign s_axi.S_AXI_WREADY  = w_ready;
   assign s_axi.S_AXI_BVALID  = !rst && (w_state_q == W_RESP);
   assign s_axi.S_AXI_BRESP   = rst ? 2'b00 : bresp_q;
   assign s_axi.S_AXI_ARREADY = ar_ready;
   assign s_axi.S_AXI_RVALID  = !rst && (r_state_q == R_DATA);
   assign s_axi.S_AXI_RRESP   = rst ? 2'b00 : rresp_q;
   assign s_axi.S_AXI_RDATA   = rst ? '0 : rdata_q;

   // Write FSM: collect AW and W in either order, commit on the edge entering W_RESP.
   always_comb begin
      w_state_d   = w_state_q;
      aw_idx_d    = aw_idx_q;
      aw_oor_d    = aw_oor_q;
      w_data_d    = w_data_q;
      w_strb_d    = w_strb_q;
      bresp_d     = bresp_q;
      commit_en   = 1'b0;
      commit_idx  = aw_idx_in;
      commit_oor  = aw_oor_in;
      commit_data = s_axi.S_AXI_WDATA;
      commit_strb = s_axi.S_AXI_WSTRB;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit_en = 1'b1;
               w_state_d = W_RESP;
            end else if (aw_hs) begin
               aw_idx_d  = aw_idx_in;
               aw_oor_d  = aw_oor_in;
               w_state_d = W_HAVE_ADDR;
            end else if (w_hs) begin
               w_data_d  = s_axi.S_AXI_WDATA;
               w_strb_d  = s_axi.S_AXI_WSTRB;
               w_state_d = W_HAVE_DATA;
            end
         end
         W_HAVE_ADDR: begin
            commit_idx = aw_idx_q;
            commit_oor = aw_oor_q;
            if (w_hs) begin
               commit_en = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_HAVE_DATA: begin
            commit_data = w_data_q;
            commit_strb = w_strb_q;
            if (aw_hs) begin
               commit_en = 1'b1;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
      if (commit_en) bresp_d = commit_oor ? 2'b10 : 2'b00;
   end

   // Write FSM state and latched AW/W fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_idx_q  <= '0;
         aw_oor_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= 2'b00;
      end else begin
         w_state_q <= w_state_d;
         aw_idx_q  <= aw_idx_d;
         aw_oor_q  <= aw_oor_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bresp_q   <= bresp_d;
      end
   end

   // Byte-masked memory write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (commit_en && !commit_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (commit_strb[i]) mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
         end
      end
   end

   // Read FSM: capture mem on AR handshake (sees pre-write data on a same-edge commit), hold until taken.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_DATA;
               rdata_d   = ar_oor_in ? '0 : mem[ar_idx_in];
               rresp_d   = ar_oor_in ? 2'b10 : 2'b00;
            end
         end
         R_DATA: begin
            if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM state and registered read response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end
endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// tb/tb_axi4_lite_ram_slave.sv - directed self-checking bench for axi4_lite_ram_slave
module tb_axi4_lite_ram_slave;
   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   axi4_lite_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi4_lite_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
      .clk   (clk),
      .rst   (rst),
      .s_axi (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Simultaneous AW+W write; lat = cycles from handshake to BVALID, -1 on timeout.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
      int n;
      @(posedge clk); #1;
      bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
      lat = -1; resp = 2'b11;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.S_AXI_BVALID) begin lat = i; resp = bus.S_AXI_BRESP; break; end
      end
      @(posedge clk); #1;
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
      int n;
      @(posedge clk); #1;
      bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.S_AXI_ARREADY && n < 20) begin
         @(negedge clk); n++;
      end
      @(posedge clk); #1;
      bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
      lat = -1; resp = 2'b11; d = 32'h0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.S_AXI_RVALID) begin lat = i; d = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP; break; end
      end
      @(posedge clk); #1;
      bus.S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
         tests_failed++; $display("FAIL reset_rdy_vld: got %b expected 00000",
            {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID});
      end
      tests_run++;
      if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== 36'h0) begin
         tests_failed++; $display("FAIL reset_resp_data: got %h expected 0", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
         tests_failed++; $display("FAIL reset_release_rdy: got %b expected 111",
            {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] resp; logic [31:0] d; int lat;
      do_write(32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
      tests_run++;
      if (lat !== 1 || resp !== 2'b00) begin
         tests_failed++; $display("FAIL simul_write: got lat=%0d resp=%b expected lat=1 resp=00", lat, resp);
      end
      do_read(32'h10, d, resp, lat);
      tests_run++;
      if (lat !== 1 || resp !== 2'b00 || d !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL simul_read: got lat=%0d resp=%b data=%h expected 1 00 deadbeef", lat, resp, d);
      end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp; logic [31:0] d; int lat;
      @(posedge clk); #1;
      bus.S_AXI_WDATA = 32'h11223344; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_WVALID = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.S_AXI_WREADY !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1 || bus.S_AXI_BVALID !== 1'b0) begin
         tests_failed++; $display("FAIL wfirst_readies: got wready=%b awready=%b bvalid=%b expected 0 1 0",
            bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID);
      end
      @(posedge clk); #1;
      bus.S_AXI_AWADDR = 32'h20; bus.S_AXI_AWVALID = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
         tests_failed++; $display("FAIL wfirst_bvalid: got bvalid=%b bresp=%b expected 1 00", bus.S_AXI_BVALID, bus.S_AXI_BRESP);
      end
      @(posedge clk); #1;
      bus.S_AXI_BREADY = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.S_AXI_BVALID !== 1'b0) begin
         tests_failed++; $display("FAIL wfirst_bdrop: got bvalid=%b expected 0", bus.S_AXI_BVALID);
      end
      do_read(32'h20, d, resp, lat);
      tests_run++;
      if (d !== 32'h11223344 || lat !== 1) begin
         tests_failed++; $display("FAIL wfirst_readback: got data=%h lat=%0d expected 11223344 1", d, lat);
      end
   endtask

   task automatic test_strobe();
      logic [1:0] resp; logic [31:0] d; int lat;
      do_write(32'h30, 32'hAABBCCDD, 4'hF, resp, lat);
      do_write(32'h30, 32'h00000011, 4'h1, resp, lat);
      do_read(32'h30, d, resp, lat);
      tests_run++;
      if (d !== 32'hAABBCC11) begin
         tests_failed++; $display("FAIL strb_merge: got %h expected aabbcc11", d);
      end
      do_write(32'h30, 32'hFFFFFFFF, 4'h0, resp, lat);
      tests_run++;
      if (resp !== 2'b00 || lat !== 1) begin
         tests_failed++; $display("FAIL strb_zero_resp: got resp=%b lat=%0d expected 00 1", resp, lat);
      end
      do_read(32'h32, d, resp, lat);
      tests_run++;
      if (d !== 32'hAABBCC11) begin
         tests_failed++; $display("FAIL strb_zero_data: got %h expected aabbcc11", d);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp; logic [31:0] d; int lat;
      @(posedge clk); #1;
      bus.S_AXI_AWADDR = 32'h50; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h5A5A5A5A; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 5'b10000) begin
            tests_failed++; $display("FAIL bp_write c%0d: got bvalid,bresp,awrdy,wrdy=%b expected 10000",
               c, {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
         end
      end
      @(posedge clk); #1;
      bus.S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_BREADY = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b1) begin
         tests_failed++; $display("FAIL bp_write_release: got bvalid=%b awready=%b expected 0 1", bus.S_AXI_BVALID, bus.S_AXI_AWREADY);
      end
      @(posedge clk); #1;
      bus.S_AXI_ARADDR = 32'h10; bus.S_AXI_ARVALID = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_ARVALID = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests_run++;
         if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'hDEADBEEF || bus.S_AXI_RRESP !== 2'b00 || bus.S_AXI_ARREADY !== 1'b0) begin
            tests_failed++; $display("FAIL bp_read c%0d: got rvalid=%b rdata=%h rresp=%b arready=%b expected 1 deadbeef 00 0",
               c, bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_ARREADY);
         end
      end
      @(posedge clk); #1;
      bus.S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_RREADY = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.S_AXI_RVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b1) begin
         tests_failed++; $display("FAIL bp_read_release: got rvalid=%b arready=%b expected 0 1", bus.S_AXI_RVALID, bus.S_AXI_ARREADY);
      end
      do_read(32'h50, d, resp, lat);
      tests_run++;
      if (d !== 32'h5A5A5A5A) begin
         tests_failed++; $display("FAIL bp_readback: got %h expected 5a5a5a5a", d);
      end
   endtask

   task automatic test_collision();
      logic [1:0] resp; logic [31:0] d; int lat;
      do_write(32'h40, 32'h1, 4'hF, resp, lat);
      @(posedge clk); #1;
      bus.S_AXI_AWADDR = 32'h40; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h2; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_ARADDR = 32'h40; bus.S_AXI_ARVALID = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== 32'h1 || bus.S_AXI_BVALID !== 1'b1) begin
         tests_failed++; $display("FAIL collide_old: got rvalid=%b rdata=%h bvalid=%b expected 1 00000001 1",
            bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_BVALID);
      end
      @(posedge clk); #1;
      bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
      do_read(32'h40, d, resp, lat);
      tests_run++;
      if (d !== 32'h2) begin
         tests_failed++; $display("FAIL collide_new: got %h expected 00000002", d);
      end
   endtask

   task automatic test_range();
      logic [1:0] resp; logic [31:0] d; int lat;
      do_write(32'h0, 32'hCAFE0000, 4'hF, resp, lat);
      do_write(32'h4000_0000, 32'h12345678, 4'hF, resp, lat);
`ifdef AXI_RAM_RANGE_CHECK_EN
      tests_run++;
      if (resp !== 2'b10 || lat !== 1) begin
         tests_failed++; $display("FAIL range_wr_resp: got resp=%b lat=%0d expected 10 1", resp, lat);
      end
      do_read(32'h4000_0000, d, resp, lat);
      tests_run++;
      if (resp !== 2'b10 || d !== 32'h0 || lat !== 1) begin
         tests_failed++; $display("FAIL range_rd: got resp=%b data=%h lat=%0d expected 10 0 1", resp, d, lat);
      end
      do_read(32'h0, d, resp, lat);
      tests_run++;
      if (d !== 32'hCAFE0000 || resp !== 2'b00) begin
         tests_failed++; $display("FAIL range_mem0: got data=%h resp=%b expected cafe0000 00", d, resp);
      end
`else
      tests_run++;
      if (resp !== 2'b00 || lat !== 1) begin
         tests_failed++; $display("FAIL alias_wr_resp: got resp=%b lat=%0d expected 00 1", resp, lat);
      end
      do_read(32'h0, d, resp, lat);
      tests_run++;
      if (d !== 32'h12345678 || resp !== 2'b00) begin
         tests_failed++; $display("FAIL alias_mem0: got data=%h resp=%b expected 12345678 00", d, resp);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [31:0] d; int lat;
      @(posedge clk); #1;
      bus.S_AXI_AWADDR = 32'h60; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h0BADF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_ARADDR = 32'h10; bus.S_AXI_ARVALID = 1'b1;
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_RVALID !== 1'b1) begin
         tests_failed++; $display("FAIL rstmid_pending: got bvalid=%b rvalid=%b expected 1 1", bus.S_AXI_BVALID, bus.S_AXI_RVALID);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 5'b0 ||
          bus.S_AXI_RDATA !== 32'h0) begin
         tests_failed++; $display("FAIL rstmid_during: got bv,rv,awr,wr,arr=%b rdata=%h expected 00000 0",
            {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, bus.S_AXI_RDATA);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 5'b00111) begin
         tests_failed++; $display("FAIL rstmid_after: got bv,rv,awr,wr,arr=%b expected 00111",
            {bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
      end
      do_read(32'h60, d, resp, lat);
      tests_run++;
      if (d !== 32'h0BADF00D || lat !== 1) begin
         tests_failed++; $display("FAIL rstmid_kept: got data=%h lat=%0d expected 0badf00d 1", d, lat);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      test_reset();
      test_simultaneous();
      test_w_before_aw();
      test_strobe();
      test_backpressure();
      test_collision();
      test_range();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/axi4_lite_ram_slave.md
Name: axi4_lite_ram_slave

Overview:
- Word-addressed RAM exposed as an AXI4-Lite slave; the downstream endpoint that consumes the master's AW/W/B and AR/R channels.
- Write and read paths are independent FSMs and can run concurrently.
- Serves as the SoC data memory and as the bench target for the master.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; fixed at 32 (WSTRB is 4 bits).
- MEM_DEPTH, 1024, number of 32-bit words; power of 2. IDX_W = log2(MEM_DEPTH).

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- S_AXI_AWADDR  input  ADDR_WIDTH  write address.
- S_AXI_AWVALID  input  1  write address valid.
- S_AXI_AWREADY  output  1  slave accepts address.
- S_AXI_WDATA  input  DATA_WIDTH  write data.
- S_AXI_WSTRB  input  4  byte enables.
- S_AXI_WVALID  input  1  write data valid.
- S_AXI_WREADY  output  1  slave accepts data.
- S_AXI_BRESP  output  2  write response.
- S_AXI_BVALID  output  1  write response valid.
- S_AXI_BREADY  input  1  master accepts response.
- S_AXI_ARADDR  input  ADDR_WIDTH  read address.
- S_AXI_ARVALID  input  1  read address valid.
- S_AXI_ARREADY  output  1  slave accepts read address.
- S_AXI_RDATA  output  DATA_WIDTH  read data.
- S_AXI_RRESP  output  2  read response.
- S_AXI_RVALID  output  1  read data valid.
- S_AXI_RREADY  input  1  master accepts read data.

Behaviour:
- Word index = addr[IDX_W+1:2]. addr[1:0] is ignored; there are no unaligned semantics.
- While rst=1:
  - All READY and VALID outputs are 0.
  - BRESP=0, RRESP=0, RDATA=0.
  - Both FSMs go to IDLE.
  - Memory contents are not reset and are undefined until written.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - AWREADY=1 in W_IDLE and W_HAVE_DATA. WREADY=1 in W_IDLE and W_HAVE_ADDR. Both are 0 in W_RESP.
  - W_IDLE: AW handshake only -> W_HAVE_ADDR (latch AWADDR). W handshake only -> W_HAVE_DATA (latch WDATA and WSTRB). Both in the same cycle -> W_RESP.
  - W_HAVE_ADDR + W handshake -> W_RESP. W_HAVE_DATA + AW handshake -> W_RESP.
  - On the edge entering W_RESP, write memory byte i only where WSTRB[i]=1, using latched or incoming values as applicable. WSTRB=0 writes nothing but still responds OKAY.
  - W_RESP: BVALID=1, BRESP=2'b00 (OKAY). Hold until BREADY=1, then return to W_IDLE with BVALID=0 the next cycle.
  - Latency: last of AW/W accepted at cycle N -> BVALID=1 at N+1. Minimum write period is 2 cycles.
- Read FSM states: R_IDLE, R_DATA.
  - ARREADY=1 only in R_IDLE.
  - AR handshake at cycle N -> RDATA = mem[idx] registered, RVALID=1, RRESP=OKAY at N+1.
  - RDATA and RRESP stay stable while RVALID=1 and RREADY=0.
  - RVALID&RREADY -> R_IDLE, RVALID=0 the next cycle. Minimum read period is 2 cycles.
- Same-edge write commit and read capture to the same word: the read returns pre-write data (read-old).
- Reset mid-transaction:
  - Latched AW/W/AR state is discarded and any pending BVALID/RVALID drops.
  - Words already committed keep their values.

Optional Feature:
- Macro: AXI_RAM_RANGE_CHECK_EN.
- Defined: an address with any nonzero bit in addr[ADDR_WIDTH-1:IDX_W+2] is out of range.
  - Out-of-range write: no memory update, BRESP=2'b10 (SLVERR).
  - Out-of-range read: RDATA=0, RRESP=2'b10.
  - Handshake timing is unchanged.
- Undefined: upper address bits are ignored (addresses alias modulo MEM_DEPTH*4) and responses are always OKAY.

Test Plan:
- Simultaneous AW+W: addr 0x10, data 0xDEADBEEF, strb 0xF -> BVALID one cycle later, BRESP=0. Read 0x10 -> RDATA=0xDEADBEEF at AR cycle+1.
- W two cycles before AW: data 0x11223344 to 0x20 -> WREADY drops after W handshake, AWREADY stays 1. BVALID one cycle after AW. Readback = 0x11223344.
- Strobe merge: write 0xAABBCCDD strb 0xF, then 0x00000011 strb 0x1 to 0x30 -> readback 0xAABBCC11. Strb 0x0 leaves 0xAABBCC11 with BRESP=OKAY.
- Backpressure: hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID, BRESP and RDATA stable. AWREADY, WREADY and ARREADY stay 0 until the respective response is taken.
- Same-edge collision: mem[0x40]=0x1, write 0x2 committing on the same edge as AR to 0x40 -> RDATA=0x1. Next read -> 0x2.
- Range and reset:
  - With the macro defined, write and read at 0x4000_0000 (MEM_DEPTH=1024) -> BRESP=2'b10, RRESP=2'b10, RDATA=0, mem[0] unchanged.
  - Without the macro, the same write lands in mem[0].
  - rst pulsed while BVALID=1 -> BVALID=0 the next cycle; all readies 0 during rst and 1 the cycle after.
